// File: rtl/register_file.sv
// 32-entry register file with two combinational read ports and one write port.
// Write data may be converted from sign-magnitude to two's complement before storage.
module register_file #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int SM_CONVERT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegisterFileWrite,
    input  logic [15:0]       sw_i,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data
);

    localparam int unsigned NUM_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0] register [0:NUM_REGS-1];
    logic [DATA_W-1:0] wr_value;
    logic              sw_unused;

    // Switches are reserved for board use and deliberately reach no logic.
    assign sw_unused = ^sw_i;

    // Negative zero falls out as 0 because the negated magnitude is 0.
    always_comb begin
        wr_value = WriteData;
        if (SM_CONVERT != 0 && WriteData[DATA_W-1]) begin
            wr_value = '0 - {1'b0, WriteData[DATA_W-2:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                register[i] <= '0;
            end
        end else if (RegisterFileWrite && rd != '0) begin
            register[rd] <= wr_value;
        end
    end

    assign rs1_data = register[rs1];
    assign rs2_data = register[rs2];

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_register_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegisterFileWrite;
    logic [15:0] sw_i;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] WriteData;
    logic [31:0] rs1_data, rs2_data;

    logic [31:0] model [32];
    int checks = 0;
    int failures = 0;

    register_file #(.DATA_W(32), .ADDR_W(5), .SM_CONVERT(1)) dut (
        .clk(clk),
        .reset(reset),
        .RegisterFileWrite(RegisterFileWrite),
        .sw_i(sw_i),
        .rs1(rs1),
        .rs2(rs2),
        .rd(rd),
        .WriteData(WriteData),
        .rs1_data(rs1_data),
        .rs2_data(rs2_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sm_to_tc(input logic [31:0] w);
        longint mag;
        mag = longint'(w & 32'h7FFF_FFFF);
        if (w[31]) return 32'(-mag);
        return w;
    endfunction

    // Advance one clock edge, updating the reference model from the driven inputs.
    task automatic cycle();
        if (!reset) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (RegisterFileWrite && rd != 5'd0) begin
            model[rd] = sm_to_tc(WriteData);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        RegisterFileWrite = 1'b1;
        rd = a;
        WriteData = d;
        cycle();
        RegisterFileWrite = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        RegisterFileWrite = 1'b0;
        sw_i = 16'h0;
        rd = 5'd0;
        WriteData = 32'h0;
        rs1 = 5'd5;
        rs2 = 5'd31;
        cycle();
        cycle();
        if (rs1_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_rs1 got=%h exp=%h", rs1_data, 32'h0);
        end
        checks++;
        if (rs2_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_rs2 got=%h exp=%h", rs2_data, 32'h0);
        end
        checks++;
        reset = 1'b1;
    endtask

    task automatic test_basic_write();
        write_reg(5'd2, 32'h0000_0005);
        rs1 = 5'd2;
        rs2 = 5'd2;
        #1;
        if (rs1_data !== 32'h0000_0005) begin
            failures++;
            $display("FAIL basic_write got=%h exp=%h", rs1_data, 32'h0000_0005);
        end
        checks++;
        if (rs2_data !== rs1_data || rs2_data !== 32'h0000_0005) begin
            failures++;
            $display("FAIL same_addr_ports got=%h exp=%h", rs2_data, 32'h0000_0005);
        end
        checks++;
    endtask

    task automatic test_sm_convert();
        write_reg(5'd3, 32'h8000_0007);
        write_reg(5'd1, 32'h8000_0000);
        write_reg(5'd6, 32'hFFFF_FFFF);
        rs1 = 5'd3;
        rs2 = 5'd1;
        #1;
        if (rs1_data !== 32'hFFFF_FFF9) begin
            failures++;
            $display("FAIL sm_neg7 got=%h exp=%h", rs1_data, 32'hFFFF_FFF9);
        end
        checks++;
        if (rs2_data !== 32'h0) begin
            failures++;
            $display("FAIL sm_negzero got=%h exp=%h", rs2_data, 32'h0);
        end
        checks++;
        rs1 = 5'd6;
        #1;
        if (rs1_data !== 32'h8000_0001) begin
            failures++;
            $display("FAIL sm_maxneg got=%h exp=%h", rs1_data, 32'h8000_0001);
        end
        checks++;
    endtask

    task automatic test_reg0();
        write_reg(5'd0, 32'h0000_0003);
        rs1 = 5'd0;
        #1;
        if (rs1_data !== 32'h0) begin
            failures++;
            $display("FAIL reg0_write got=%h exp=%h", rs1_data, 32'h0);
        end
        checks++;
    endtask

    task automatic test_read_during_write();
        write_reg(5'd4, 32'h0000_0009);
        rs1 = 5'd4;
        rd = 5'd4;
        WriteData = 32'h0000_0006;
        RegisterFileWrite = 1'b1;
        #1;
        if (rs1_data !== 32'h0000_0009) begin
            failures++;
            $display("FAIL rdw_before got=%h exp=%h", rs1_data, 32'h0000_0009);
        end
        checks++;
        cycle();
        if (rs1_data !== 32'h0000_0006) begin
            failures++;
            $display("FAIL rdw_after got=%h exp=%h", rs1_data, 32'h0000_0006);
        end
        checks++;
        RegisterFileWrite = 1'b0;
        WriteData = 32'h1234_5678;
        for (int i = 0; i < 3; i++) cycle();
        if (rs1_data !== 32'h0000_0006) begin
            failures++;
            $display("FAIL hold got=%h exp=%h", rs1_data, 32'h0000_0006);
        end
        checks++;
    endtask

    task automatic test_reset_priority();
        write_reg(5'd2, 32'h0000_00AA);
        reset = 1'b0;
        RegisterFileWrite = 1'b1;
        rd = 5'd2;
        WriteData = 32'h0000_0055;
        cycle();
        reset = 1'b1;
        RegisterFileWrite = 1'b0;
        rs1 = 5'd2;
        #1;
        if (rs1_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_priority got=%h exp=%h", rs1_data, 32'h0);
        end
        checks++;
        write_reg(5'd7, 32'h8000_0010);
        rs1 = 5'd7;
        rs2 = 5'd2;
        for (int i = 0; i < 16; i++) begin
            sw_i = sw_i ^ (16'h1 << i);
            #1;
            if (rs1_data !== model[7] || rs2_data !== model[2]) begin
                failures++;
                $display("FAIL sw_i_effect bit=%0d got=%h/%h exp=%h/%h",
                         i, rs1_data, rs2_data, model[7], model[2]);
            end
            checks++;
        end
    endtask

    task automatic test_reset_discard();
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'hC0DE_0000 | 32'(i));
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i);
            rs2 = 5'(31 - i);
            #1;
            if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
                failures++;
                $display("FAIL reset_discard reg=%0d got=%h/%h exp=0", i, rs1_data, rs2_data);
            end
            checks++;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 39) != 0);
            RegisterFileWrite = $urandom_range(0, 2) != 0;
            rd = 5'($urandom_range(0, 31));
            WriteData = $urandom;
            sw_i = 16'($urandom);
            rs1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            rs2 = 5'($urandom_range(0, 31));
            #1;
            if (rs1_data !== model[rs1]) begin
                failures++;
                $display("FAIL rand_rs1 n=%0d addr=%0d got=%h exp=%h", n, rs1, rs1_data, model[rs1]);
            end
            checks++;
            if (rs2_data !== model[rs2]) begin
                failures++;
                $display("FAIL rand_rs2 n=%0d addr=%0d got=%h exp=%h", n, rs2, rs2_data, model[rs2]);
            end
            checks++;
            cycle();
        end
        reset = 1'b1;
        RegisterFileWrite = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_sm_convert();
        test_reg0();
        test_read_during_write();
        test_reset_priority();
        test_reset_discard();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 32, data word width in bits.
REQ-002 The block SHALL provide parameter ADDR_W, default 5, register address width, giving 2**ADDR_W = 32 registers.
REQ-003 The block SHALL provide parameter SM_CONVERT, default 1: 1 = write data is sign-magnitude and is stored as two's complement; 0 = stored verbatim.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-006 RegisterFileWrite  input  1  write enable; 1 = write on the next rising clk.
REQ-007 sw_i  input  16  board switch vector; reserved, SHALL NOT affect any behaviour.
REQ-008 rs1  input  ADDR_W  read address, port 1.
REQ-009 rs2  input  ADDR_W  read address, port 2.
REQ-010 rd  input  ADDR_W  write address.
REQ-011 WriteData  input  DATA_W  write data; bit DATA_W-1 is the sign, bits DATA_W-2:0 are the magnitude when SM_CONVERT=1.
REQ-012 rs1_data  output  DATA_W  contents of register rs1.
REQ-013 rs2_data  output  DATA_W  contents of register rs2.
REQ-014 The storage SHALL be an array named register, indexed 0..31, DATA_W bits per entry, and SHALL stay readable by hierarchical reference from the parent for the debug display.

Function
REQ-015 Reads SHALL be combinational: rs1_data = register[rs1] and rs2_data = register[rs2], with zero clock latency.
REQ-016 A write SHALL occur on a rising clk when reset=1, RegisterFileWrite=1 and rd != 0.
REQ-017 With SM_CONVERT=1 and WriteData[DATA_W-1]=0, the stored value SHALL be WriteData unchanged.
REQ-018 With SM_CONVERT=1 and WriteData[DATA_W-1]=1, the stored value SHALL be the two's complement negation of the zero-extended magnitude WriteData[DATA_W-2:0], truncated to DATA_W bits.
REQ-019 Negative zero (sign=1, magnitude=0) SHALL be stored as 0.
REQ-020 Register 0 SHALL always read 0; writes to rd=0 SHALL be ignored.
REQ-021 Read-during-write to the same address SHALL have no bypass: the read port returns the old value until the write edge, then the new value.
REQ-022 Both read ports SHALL be allowed to address the same register at once, and both SHALL return the same value.
REQ-023 When RegisterFileWrite=0, all registers SHALL hold their values.
REQ-024 The block SHALL contain no other state, no handshake, and no multi-cycle operation.

Reset
REQ-025 When reset=0 at a rising clk, all 32 registers SHALL clear to 0 on that edge.
REQ-026 Reset SHALL take priority over a simultaneous write; the write SHALL be dropped.
REQ-027 While reset is held low, rs1_data and rs2_data SHALL read 0 from the first rising edge onward.
REQ-028 A reset asserted between writes SHALL discard all earlier writes.
REQ-029 Register contents before the first reset edge are undefined; the bench SHALL apply reset first.

Verification
REQ-030 Reset low for 2 cycles, then rs1=5, rs2=31 -> rs1_data=0, rs2_data=0.
REQ-031 Write rd=2, WriteData=32'h0000_0005, RegisterFileWrite=1 for one cycle, then rs1=2 -> rs1_data=32'h0000_0005.
REQ-032 Write rd=3, WriteData=32'h8000_0007 -> register[3]=32'hFFFF_FFF9 (-7); write rd=1, WriteData=32'h8000_0000 -> register[1]=0.
REQ-033 Write rd=0, WriteData=32'h0000_0003 -> rs1=0 still reads 0.
REQ-034 With rs1=4, write rd=4, WriteData=32'h0000_0006 -> rs1_data keeps the old value before the edge and reads 6 after it; RegisterFileWrite=0 on later cycles keeps 6.
REQ-035 With reset=0 and RegisterFileWrite=1 on the same edge, rd=2 -> register[2]=0, and toggling any sw_i bit changes no output.
